// File: rtl/mem_access_if.sv
// Bundle of the EX-side handshake, data-bus and write-back signals for mem_access.
// master = the mem_access stage itself, slave = its surroundings (EX stage, bus, WB).
interface mem_access_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_c;
  logic [31:0] ex_st_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_we;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        mis_excp;

  modport master (
    input  ex_valid, ex_alu_c, ex_st_data, ex_mem_op, ex_rd, ex_we,
    input  dbus_gnt, dbus_rvalid, dbus_rdata,
    output ex_ready,
    output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
    output wb_valid, wb_data, wb_rd, wb_we, mis_excp
  );

  modport slave (
    output ex_valid, ex_alu_c, ex_st_data, ex_mem_op, ex_rd, ex_we,
    output dbus_gnt, dbus_rvalid, dbus_rdata,
    input  ex_ready,
    input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
    input  wb_valid, wb_data, wb_rd, wb_we, mis_excp
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: request/grant/response data-bus transactions and one write-back record per op.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
//
// state | meaning
// IDLE  | ready for a new op; NONE ops retire from here in one cycle
// REQ   | dbus_req held with stable address/strobes/data until dbus_gnt
// RESP  | load granted, waiting for dbus_rvalid
module mem_access (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.master bus
);

  localparam logic [3:0] OP_LD_B  = 4'd1;
  localparam logic [3:0] OP_LD_H  = 4'd2;
  localparam logic [3:0] OP_LD_W  = 4'd3;
  localparam logic [3:0] OP_LD_BU = 4'd4;
  localparam logic [3:0] OP_LD_HU = 4'd5;
  localparam logic [3:0] OP_ST_B  = 4'd6;
  localparam logic [3:0] OP_ST_H  = 4'd7;
  localparam logic [3:0] OP_ST_W  = 4'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;

  logic        dbus_req_q, dbus_req_d;
  logic        dbus_we_q, dbus_we_d;
  logic [31:0] dbus_addr_q, dbus_addr_d;
  logic [3:0]  dbus_wstrb_q, dbus_wstrb_d;
  logic [31:0] dbus_wdata_q, dbus_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        mis_excp_q, mis_excp_d;

  logic        is_load, is_store, is_half, is_word, misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    is_load  = (bus.ex_mem_op >= OP_LD_B) && (bus.ex_mem_op <= OP_LD_HU);
    is_store = (bus.ex_mem_op >= OP_ST_B) && (bus.ex_mem_op <= OP_ST_W);
    is_half  = (bus.ex_mem_op == OP_LD_H) || (bus.ex_mem_op == OP_LD_HU) ||
               (bus.ex_mem_op == OP_ST_H);
    is_word  = (bus.ex_mem_op == OP_LD_W) || (bus.ex_mem_op == OP_ST_W);
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_half && bus.ex_alu_c[0]) ||
                      (is_word && (bus.ex_alu_c[1:0] != 2'b00));
`else
  // Without the trap, low address bits are simply dropped by lane selection.
  assign misaligned = 1'b0;
`endif

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    case (bus.ex_mem_op)
      OP_ST_B: begin
        st_wstrb = 4'b0001 << bus.ex_alu_c[1:0];
        st_wdata = {4{bus.ex_st_data[7:0]}};
      end
      OP_ST_H: begin
        st_wstrb = bus.ex_alu_c[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.ex_st_data[15:0]}};
      end
      OP_ST_W: begin
        st_wstrb = 4'b1111;
        st_wdata = bus.ex_st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.dbus_rdata[7:0];
      2'd1:    ld_byte = bus.dbus_rdata[15:8];
      2'd2:    ld_byte = bus.dbus_rdata[23:16];
      default: ld_byte = bus.dbus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
    case (op_q)
      OP_LD_B:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LD_BU: ld_ext = {24'h0, ld_byte};
      OP_LD_H:  ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LD_HU: ld_ext = {16'h0, ld_half};
      default:  ld_ext = bus.dbus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    rd_d         = rd_q;
    we_d         = we_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_wstrb_d = dbus_wstrb_q;
    dbus_wdata_d = dbus_wdata_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    mis_excp_d   = mis_excp_q;

    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.ex_alu_c;
            wb_rd_d    = bus.ex_rd;
            wb_we_d    = 1'b0;
            mis_excp_d = 1'b1;
          end else if (is_load || is_store) begin
            addr_d       = bus.ex_alu_c;
            op_d         = bus.ex_mem_op;
            rd_d         = bus.ex_rd;
            we_d         = bus.ex_we && !is_store;
            dbus_req_d   = 1'b1;
            dbus_we_d    = is_store;
            dbus_addr_d  = {bus.ex_alu_c[31:2], 2'b00};
            dbus_wstrb_d = st_wstrb;
            dbus_wdata_d = st_wdata;
            state_d      = REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.ex_alu_c;
            wb_rd_d    = bus.ex_rd;
            wb_we_d    = bus.ex_we;
            mis_excp_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (bus.dbus_gnt) begin
          dbus_req_d = 1'b0;
          if (op_q >= OP_ST_B) begin
            // Stores retire with the address as data, never writing a register.
            wb_valid_d = 1'b1;
            wb_data_d  = addr_q;
            wb_rd_d    = rd_q;
            wb_we_d    = 1'b0;
            mis_excp_d = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.dbus_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_ext;
          wb_rd_d    = rd_q;
          wb_we_d    = we_q;
          mis_excp_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      op_q         <= 4'h0;
      rd_q         <= 5'h0;
      we_q         <= 1'b0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= 32'h0;
      dbus_wstrb_q <= 4'h0;
      dbus_wdata_q <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'h0;
      wb_rd_q      <= 5'h0;
      wb_we_q      <= 1'b0;
      mis_excp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      we_q         <= we_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_wstrb_q <= dbus_wstrb_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      mis_excp_q   <= mis_excp_d;
    end
  end

  assign bus.ex_ready   = (state_q == IDLE);
  assign bus.dbus_req   = dbus_req_q;
  assign bus.dbus_we    = dbus_we_q;
  assign bus.dbus_addr  = dbus_addr_q;
  assign bus.dbus_wstrb = dbus_wstrb_q;
  assign bus.dbus_wdata = dbus_wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.mis_excp   = mis_excp_q;

endmodule
